// File: rtl/sal_timing_cfg.sv
// sal_timing_cfg: APB-programmable DDR timing profiles.
// Holds NUM_SETS software-writable timing sets and drives the bank and
// scheduler timing outputs from the single active set. Switching sets goes
// through an upd_req/upd_ack handshake so outputs only move while the
// controller is idle.
// Optional build macro: SAL_CFG_LIVE_UPDATE_EN allows writes to the active
// set, which are then pushed to the outputs through the normal handshake.
module sal_timing_cfg #(
    parameter int NUM_SETS = 2,
    localparam int SEL_W = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             psel,
    input  logic             penable,
    input  logic             pwrite,
    input  logic [11:0]      paddr,
    input  logic [31:0]      pwdata,
    output logic [31:0]      prdata,
    output logic             pready,
    output logic             pslverr,
    output logic             upd_req,
    input  logic             upd_ack,
    output logic [7:0]       t_rcd_m1,
    output logic [7:0]       t_rp_m1,
    output logic [7:0]       t_ras_m1,
    output logic [7:0]       t_rfc_m1,
    output logic [7:0]       t_rtp_m1,
    output logic [7:0]       t_wtp_m1,
    output logic [7:0]       t_rrd_m1,
    output logic [7:0]       t_ccd_m1,
    output logic [7:0]       t_wtr_m1,
    output logic [7:0]       t_rtw_m1,
    output logic [3:0]       dfi_wren_lat,
    output logic [3:0]       dfi_rden_lat,
    output logic [SEL_W-1:0] active_set
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_APPLY = 2'd2;

    localparam logic [31:0] RST_BK0  = 32'h020D_0404;
    localparam logic [15:0] RST_BK1  = 16'h3208;
    localparam logic [31:0] RST_SCH  = 32'h0302_0102;
    localparam logic [3:0]  RST_WREN = 4'd4;
    localparam logic [3:0]  RST_RDEN = 4'd6;

    localparam logic [3:0]  NUM_SETS_4  = 4'(NUM_SETS);
    localparam logic [31:0] NUM_SETS_32 = 32'(NUM_SETS);

    logic [1:0]       state_q, state_d;
    logic [SEL_W-1:0] active_set_q, active_set_d;
    logic [SEL_W-1:0] pend_set_q, pend_set_d;
    logic             upd_req_q, upd_req_d;
    logic [31:0]      prdata_q, prdata_d;

    logic [31:0] bk0_q [NUM_SETS];
    logic [31:0] bk0_d [NUM_SETS];
    logic [15:0] bk1_q [NUM_SETS];
    logic [15:0] bk1_d [NUM_SETS];
    logic [31:0] sch_q [NUM_SETS];
    logic [31:0] sch_d [NUM_SETS];
    logic [3:0]  wren_q [NUM_SETS];
    logic [3:0]  wren_d [NUM_SETS];
    logic [3:0]  rden_q [NUM_SETS];
    logic [3:0]  rden_d [NUM_SETS];

    logic [31:0] out_bk0_q, out_bk0_d;
    logic [15:0] out_bk1_q, out_bk1_d;
    logic [31:0] out_sch_q, out_sch_d;
    logic [3:0]  out_wren_q, out_wren_d;
    logic [3:0]  out_rden_q, out_rden_d;

    logic             is_ctrl, is_status, set_hit, set_ok;
    logic             pending, req_ok, wr_reject, access_err;
    logic             apb_access, wr_commit;
    logic [3:0]       set_idx;
    logic [SEL_W-1:0] set_sel, req_set;
    logic [1:0]       reg_sel;
    logic [31:0]      status_word, rd_data;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^paddr[1:0];

    assign set_idx    = paddr[7:4];
    assign set_sel    = set_idx[SEL_W-1:0];
    assign reg_sel    = paddr[3:2];
    assign is_ctrl    = (paddr[11:2] == 10'd0);
    assign is_status  = (paddr[11:2] == 10'd1);
    assign set_hit    = (paddr[11:8] == 4'h1);
    assign set_ok     = set_hit && (set_idx < NUM_SETS_4);
    assign pending    = (state_q != ST_IDLE);
    assign req_ok     = (pwdata < NUM_SETS_32);
    assign req_set    = pwdata[SEL_W-1:0];
    assign apb_access = psel && penable;

    // Decide whether a write to the decoded register must be refused
    always_comb begin
        wr_reject = 1'b0;
        if (is_status) begin
            wr_reject = 1'b1;
        end else if (is_ctrl) begin
            wr_reject = pending || !req_ok;
        end else if (set_ok) begin
            if (pending && (set_sel == pend_set_q)) begin
                wr_reject = 1'b1;
            end
`ifdef SAL_CFG_LIVE_UPDATE_EN
`else
            if (set_sel == active_set_q) begin
                wr_reject = 1'b1;
            end
`endif
        end
    end

    assign access_err = !(is_ctrl || is_status || set_ok) || (pwrite && wr_reject);
    assign wr_commit  = apb_access && pwrite && !access_err;
    assign pslverr    = apb_access && access_err;
    assign pready     = 1'b1;

    // Assemble the STATUS word and the read mux for the addressed register
    always_comb begin
        status_word                = '0;
        status_word[SEL_W-1:0]     = active_set_q;
        status_word[8]             = pending;
        status_word[16 +: SEL_W]   = pend_set_q;
        rd_data                    = '0;
        if (is_status) begin
            rd_data = status_word;
        end else if (set_ok) begin
            case (reg_sel)
                2'd0: rd_data = bk0_q[set_sel];
                2'd1: rd_data = {16'h0, bk1_q[set_sel]};
                2'd2: rd_data = sch_q[set_sel];
                2'd3: rd_data = {20'h0, rden_q[set_sel], 4'h0, wren_q[set_sel]};
            endcase
        end
    end

    // Register file updates and read data captured in the setup phase
    always_comb begin
        bk0_d    = bk0_q;
        bk1_d    = bk1_q;
        sch_d    = sch_q;
        wren_d   = wren_q;
        rden_d   = rden_q;
        prdata_d = (psel && !penable && !pwrite) ? rd_data : 32'h0;
        if (wr_commit && set_ok) begin
            case (reg_sel)
                2'd0: bk0_d[set_sel] = pwdata;
                2'd1: bk1_d[set_sel] = pwdata[15:0];
                2'd2: sch_d[set_sel] = pwdata;
                2'd3: begin
                    wren_d[set_sel] = pwdata[3:0];
                    rden_d[set_sel] = pwdata[11:8];
                end
            endcase
        end
    end

    // Update handshake: request a switch, wait for ack, then load the outputs
    always_comb begin
        state_d      = state_q;
        active_set_d = active_set_q;
        pend_set_d   = pend_set_q;
        upd_req_d    = upd_req_q;
        out_bk0_d    = out_bk0_q;
        out_bk1_d    = out_bk1_q;
        out_sch_d    = out_sch_q;
        out_wren_d   = out_wren_q;
        out_rden_d   = out_rden_q;
        case (state_q)
            ST_IDLE: begin
                if (wr_commit && is_ctrl && (req_set != active_set_q)) begin
                    pend_set_d = req_set;
                    upd_req_d  = 1'b1;
                    state_d    = ST_REQ;
                end
`ifdef SAL_CFG_LIVE_UPDATE_EN
                else if (wr_commit && set_ok && (set_sel == active_set_q)) begin
                    pend_set_d = active_set_q;
                    upd_req_d  = 1'b1;
                    state_d    = ST_REQ;
                end
`endif
            end
            ST_REQ: begin
                if (upd_ack) begin
                    state_d = ST_APPLY;
                end
            end
            ST_APPLY: begin
                out_bk0_d    = bk0_q[pend_set_q];
                out_bk1_d    = bk1_q[pend_set_q];
                out_sch_d    = sch_q[pend_set_q];
                out_wren_d   = wren_q[pend_set_q];
                out_rden_d   = rden_q[pend_set_q];
                active_set_d = pend_set_q;
                upd_req_d    = 1'b0;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset to the default profile
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            active_set_q <= '0;
            pend_set_q   <= '0;
            upd_req_q    <= 1'b0;
            prdata_q     <= 32'h0;
            for (int s = 0; s < NUM_SETS; s++) begin
                bk0_q[s]  <= RST_BK0;
                bk1_q[s]  <= RST_BK1;
                sch_q[s]  <= RST_SCH;
                wren_q[s] <= RST_WREN;
                rden_q[s] <= RST_RDEN;
            end
            out_bk0_q  <= RST_BK0;
            out_bk1_q  <= RST_BK1;
            out_sch_q  <= RST_SCH;
            out_wren_q <= RST_WREN;
            out_rden_q <= RST_RDEN;
        end else begin
            state_q      <= state_d;
            active_set_q <= active_set_d;
            pend_set_q   <= pend_set_d;
            upd_req_q    <= upd_req_d;
            prdata_q     <= prdata_d;
            bk0_q        <= bk0_d;
            bk1_q        <= bk1_d;
            sch_q        <= sch_d;
            wren_q       <= wren_d;
            rden_q       <= rden_d;
            out_bk0_q    <= out_bk0_d;
            out_bk1_q    <= out_bk1_d;
            out_sch_q    <= out_sch_d;
            out_wren_q   <= out_wren_d;
            out_rden_q   <= out_rden_d;
        end
    end

    assign prdata       = prdata_q;
    assign upd_req      = upd_req_q;
    assign active_set   = active_set_q;
    assign t_rcd_m1     = out_bk0_q[7:0];
    assign t_rp_m1      = out_bk0_q[15:8];
    assign t_ras_m1     = out_bk0_q[23:16];
    assign t_rtp_m1     = out_bk0_q[31:24];
    assign t_wtp_m1     = out_bk1_q[7:0];
    assign t_rfc_m1     = out_bk1_q[15:8];
    assign t_rrd_m1     = out_sch_q[7:0];
    assign t_ccd_m1     = out_sch_q[15:8];
    assign t_wtr_m1     = out_sch_q[23:16];
    assign t_rtw_m1     = out_sch_q[31:24];
    assign dfi_wren_lat = out_wren_q;
    assign dfi_rden_lat = out_rden_q;

endmodule

// File: tb/tb_sal_timing_cfg.sv
// tb_sal_timing_cfg: self-checking bench for sal_timing_cfg.
// A field-level model of the timing sets and the switch handshake predicts
// every APB response and every output value.
module tb_sal_timing_cfg;

    localparam int NUM_SETS = 2;
    localparam int SEL_W = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1;

    logic             clk;
    logic             rst;
    logic             psel, penable, pwrite;
    logic [11:0]      paddr;
    logic [31:0]      pwdata;
    logic [31:0]      prdata;
    logic             pready, pslverr;
    logic             upd_req, upd_ack;
    logic [7:0]       t_rcd_m1, t_rp_m1, t_ras_m1, t_rfc_m1, t_rtp_m1, t_wtp_m1;
    logic [7:0]       t_rrd_m1, t_ccd_m1, t_wtr_m1, t_rtw_m1;
    logic [3:0]       dfi_wren_lat, dfi_rden_lat;
    logic [SEL_W-1:0] active_set;

    int checks = 0;
    int errors = 0;

    sal_timing_cfg #(.NUM_SETS(NUM_SETS)) dut (
        .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .upd_req(upd_req), .upd_ack(upd_ack),
        .t_rcd_m1(t_rcd_m1), .t_rp_m1(t_rp_m1), .t_ras_m1(t_ras_m1),
        .t_rfc_m1(t_rfc_m1), .t_rtp_m1(t_rtp_m1), .t_wtp_m1(t_wtp_m1),
        .t_rrd_m1(t_rrd_m1), .t_ccd_m1(t_ccd_m1), .t_wtr_m1(t_wtr_m1),
        .t_rtw_m1(t_rtw_m1), .dfi_wren_lat(dfi_wren_lat),
        .dfi_rden_lat(dfi_rden_lat), .active_set(active_set)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] rcd, rp, ras, rtp, wtp, rfc, rrd, ccd, wtr, rtw;
        logic [3:0] wren, rden;
    } timing_t;

    logic [87:0] dut_outs;
    assign dut_outs = {t_rcd_m1, t_rp_m1, t_ras_m1, t_rtp_m1, t_wtp_m1, t_rfc_m1,
                       t_rrd_m1, t_ccd_m1, t_wtr_m1, t_rtw_m1, dfi_wren_lat, dfi_rden_lat};

    // Reference model state
    timing_t m_set [NUM_SETS];
    timing_t m_out;
    int      m_active;
    int      m_pend_set;
    bit      m_pending;

    function automatic timing_t def_timing();
        timing_t t;
        t.rcd = 8'd4;  t.rp = 8'd4;   t.ras = 8'd13; t.rtp = 8'd2;
        t.wtp = 8'd8;  t.rfc = 8'd50; t.rrd = 8'd2;  t.ccd = 8'd1;
        t.wtr = 8'd2;  t.rtw = 8'd3;  t.wren = 4'd4; t.rden = 4'd6;
        return t;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < NUM_SETS; i++) m_set[i] = def_timing();
        m_out = def_timing();
        m_active = 0;
        m_pend_set = 0;
        m_pending = 1'b0;
    endfunction

    function automatic void m_apply();
        m_out = m_set[m_pend_set];
        m_active = m_pend_set;
        m_pending = 1'b0;
    endfunction

    function automatic logic [31:0] m_word(int s, int r);
        timing_t t = m_set[s];
        case (r)
            0: return {t.rtp, t.ras, t.rp, t.rcd};
            1: return {16'h0, t.rfc, t.wtp};
            2: return {t.rtw, t.wtr, t.ccd, t.rrd};
            default: return {20'h0, t.rden, 4'h0, t.wren};
        endcase
    endfunction

    // Applies a write to the model and returns the expected error flag
    function automatic bit m_write(logic [11:0] a, logic [31:0] d);
        int word = int'(a[11:2]);
        int s = int'(a[7:4]);
        int r = int'(a[3:2]);
        if (word == 0) begin
            if (m_pending || d >= 32'(NUM_SETS)) return 1'b1;
            if (int'(d) != m_active) begin
                m_pend_set = int'(d);
                m_pending = 1'b1;
            end
            return 1'b0;
        end
        if (word == 1) return 1'b1;
        if (a[11:8] == 4'h1 && s < NUM_SETS) begin
            if (m_pending && s == m_pend_set) return 1'b1;
            if (s == m_active) begin
`ifdef SAL_CFG_LIVE_UPDATE_EN
                if (!m_pending) begin
                    m_pend_set = s;
                    m_pending = 1'b1;
                end
`else
                return 1'b1;
`endif
            end
            case (r)
                0: begin m_set[s].rcd = d[7:0]; m_set[s].rp = d[15:8];
                         m_set[s].ras = d[23:16]; m_set[s].rtp = d[31:24]; end
                1: begin m_set[s].wtp = d[7:0]; m_set[s].rfc = d[15:8]; end
                2: begin m_set[s].rrd = d[7:0]; m_set[s].ccd = d[15:8];
                         m_set[s].wtr = d[23:16]; m_set[s].rtw = d[31:24]; end
                default: begin m_set[s].wren = d[3:0]; m_set[s].rden = d[11:8]; end
            endcase
            return 1'b0;
        end
        return 1'b1;
    endfunction

    // Returns {expected error, expected read data}
    function automatic logic [32:0] m_read(logic [11:0] a);
        int word = int'(a[11:2]);
        int s = int'(a[7:4]);
        if (word == 0) return {1'b0, 32'h0};
        if (word == 1) return {1'b0, 32'((m_pend_set << 16) | (int'(m_pending) << 8) | m_active)};
        if (a[11:8] == 4'h1 && s < NUM_SETS) return {1'b0, m_word(s, int'(a[3:2]))};
        return {1'b1, 32'h0};
    endfunction

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apb_write(input logic [11:0] a, input logic [31:0] d, output logic err);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        #1;
        err = pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic err);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(posedge clk); #1;
        penable = 1'b1;
        #1;
        d = prdata;
        err = pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic e;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        m_reset();
        checks++; if (dut_outs !== m_out) begin errors++; $display("[TB] FAIL reset_outs: got %h expected %h", dut_outs, m_out); end
        checks++; if ({t_rcd_m1, t_rfc_m1, dfi_wren_lat, dfi_rden_lat} !== {8'd4, 8'd50, 4'd4, 4'd6}) begin
            errors++; $display("[TB] FAIL reset_key_fields: got %h expected %h", {t_rcd_m1, t_rfc_m1, dfi_wren_lat, dfi_rden_lat}, {8'd4, 8'd50, 4'd4, 4'd6}); end
        checks++; if ({upd_req, active_set, pslverr, pready} !== {1'b0, SEL_W'(0), 1'b0, 1'b1}) begin
            errors++; $display("[TB] FAIL reset_ctrl: got %b expected %b", {upd_req, active_set, pslverr, pready}, {1'b0, SEL_W'(0), 1'b0, 1'b1}); end
        checks++; if (prdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_prdata: got %h expected 0", prdata); end
        apb_read(12'h100, d, e);
        checks++; if ({e, d} !== {1'b0, 32'h020D0404}) begin errors++; $display("[TB] FAIL reset_read_bk0: got %h expected %h", {e, d}, {1'b0, 32'h020D0404}); end
        checks++; if (prdata !== 32'h0) begin errors++; $display("[TB] FAIL prdata_after_access: got %h expected 0", prdata); end
        apb_read(12'h004, d, e);
        checks++; if ({e, d} !== 33'h0) begin errors++; $display("[TB] FAIL reset_read_status: got %h expected 0", {e, d}); end
    endtask

    task automatic test_switch();
        logic e;
        bit x;
        x = m_write(12'h110, 32'h03100505); apb_write(12'h110, 32'h03100505, e);
        checks++; if (e !== x) begin errors++; $display("[TB] FAIL sw_wr_bk0: got %b expected %b", e, x); end
        x = m_write(12'h11C, 32'h00000705); apb_write(12'h11C, 32'h00000705, e);
        checks++; if (e !== x) begin errors++; $display("[TB] FAIL sw_wr_lat: got %b expected %b", e, x); end
        x = m_write(12'h000, 32'h1); apb_write(12'h000, 32'h1, e);
        checks++; if (e !== x) begin errors++; $display("[TB] FAIL sw_ctrl: got %b expected %b", e, x); end
        upd_ack = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checks++; if ({upd_req, dut_outs} !== {1'b1, m_out}) begin
                errors++; $display("[TB] FAIL sw_wait%0d: got %h expected %h", i, {upd_req, dut_outs}, {1'b1, m_out}); end
            tick(1);
        end
        upd_ack = 1'b1;
        tick(1);
        upd_ack = 1'b0;
        checks++; if ({upd_req, dut_outs} !== {1'b1, m_out}) begin
            errors++; $display("[TB] FAIL sw_apply_cycle: got %h expected %h", {upd_req, dut_outs}, {1'b1, m_out}); end
        tick(1);
        m_apply();
        checks++; if (dut_outs !== m_out) begin errors++; $display("[TB] FAIL sw_new_outs: got %h expected %h", dut_outs, m_out); end
        checks++; if ({t_rcd_m1, t_ras_m1, t_rtp_m1, dfi_wren_lat, dfi_rden_lat, upd_req} !== {8'd5, 8'h10, 8'd3, 4'd5, 4'd7, 1'b0}) begin
            errors++; $display("[TB] FAIL sw_fields: got %h expected %h", {t_rcd_m1, t_ras_m1, t_rtp_m1, dfi_wren_lat, dfi_rden_lat, upd_req}, {8'd5, 8'h10, 8'd3, 4'd5, 4'd7, 1'b0}); end
        checks++; if (active_set !== SEL_W'(1)) begin errors++; $display("[TB] FAIL sw_active: got %0d expected 1", active_set); end
    endtask

    task automatic test_errors();
        logic [11:0] ea [9];
        logic [31:0] ed [9];
        bit          ew [9];
        logic [31:0] rd;
        logic [32:0] rexp;
        logic        got;
        bit          x;
        ea = '{12'h000, 12'h000, 12'h000, 12'h200, 12'h100, 12'h110, 12'h004, 12'h120, 12'h124};
        ed = '{32'd0, 32'd1, 32'd7, 32'd0, $urandom, $urandom, $urandom, $urandom, 32'd0};
        ew = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 9; i++) begin
            if (ew[i]) begin
                x = m_write(ea[i], ed[i]);
                apb_write(ea[i], ed[i], got);
            end else begin
                rexp = m_read(ea[i]);
                x = rexp[32];
                apb_read(ea[i], rd, got);
            end
            checks++; if (got !== x) begin errors++; $display("[TB] FAIL err_case%0d: pslverr got %b expected %b", i, got, x); end
            checks++; if (upd_req !== m_pending) begin errors++; $display("[TB] FAIL err_req%0d: got %b expected %b", i, upd_req, m_pending); end
        end
        rexp = m_read(12'h004);
        apb_read(12'h004, rd, got);
        checks++; if ({got, rd} !== rexp) begin errors++; $display("[TB] FAIL err_status: got %h expected %h", {got, rd}, rexp); end
        upd_ack = 1'b1; tick(1); upd_ack = 1'b0; tick(1);
        if (m_pending) m_apply();
        checks++; if ({active_set, dut_outs} !== {SEL_W'(m_active), m_out}) begin
            errors++; $display("[TB] FAIL err_resolve: got %h expected %h", {active_set, dut_outs}, {SEL_W'(m_active), m_out}); end
        x = m_write(12'h000, 32'(m_active));
        apb_write(12'h000, 32'(m_active), got);
        checks++; if ({got, upd_req} !== {x, m_pending}) begin
            errors++; $display("[TB] FAIL noop_ctrl: got %b expected %b", {got, upd_req}, {x, m_pending}); end
    endtask

    task automatic test_back_to_back();
        logic        e;
        bit          x;
        int          tgt;
        logic [31:0] d;
        tgt = (m_active + 1) % NUM_SETS;
        d = $urandom;
        x = m_write(12'h100 + 12'(16 * tgt), d); apb_write(12'h100 + 12'(16 * tgt), d, e);
        checks++; if (e !== x) begin errors++; $display("[TB] FAIL b2b_wr: got %b expected %b", e, x); end
        upd_ack = 1'b1;
        x = m_write(12'h000, 32'(tgt)); apb_write(12'h000, 32'(tgt), e);
        checks++; if ({e, upd_req, dut_outs} !== {x, 1'b1, m_out}) begin
            errors++; $display("[TB] FAIL b2b_req: got %h expected %h", {e, upd_req, dut_outs}, {x, 1'b1, m_out}); end
        tick(1);
        checks++; if ({upd_req, dut_outs} !== {1'b1, m_out}) begin
            errors++; $display("[TB] FAIL b2b_apply: got %h expected %h", {upd_req, dut_outs}, {1'b1, m_out}); end
        tick(1);
        m_apply();
        checks++; if ({upd_req, active_set, dut_outs} !== {1'b0, SEL_W'(m_active), m_out}) begin
            errors++; $display("[TB] FAIL b2b_done: got %h expected %h", {upd_req, active_set, dut_outs}, {1'b0, SEL_W'(m_active), m_out}); end
        tick(3);
        upd_ack = 1'b0;
        checks++; if ({upd_req, active_set, dut_outs} !== {1'b0, SEL_W'(m_active), m_out}) begin
            errors++; $display("[TB] FAIL idle_ack_ignored: got %h expected %h", {upd_req, active_set, dut_outs}, {1'b0, SEL_W'(m_active), m_out}); end
    endtask

    task automatic test_reset_in_req();
        logic        e;
        bit          x;
        logic [31:0] d;
        logic [32:0] rexp;
        if (m_active != 0) begin
            x = m_write(12'h000, 32'h0); apb_write(12'h000, 32'h0, e);
            upd_ack = 1'b1; tick(1); upd_ack = 1'b0; tick(1);
            if (m_pending) m_apply();
        end
        for (int r = 0; r < 4; r++) begin
            d = $urandom;
            x = m_write(12'h110 + 12'(4 * r), d); apb_write(12'h110 + 12'(4 * r), d, e);
        end
        x = m_write(12'h000, 32'h1); apb_write(12'h000, 32'h1, e);
        checks++; if ({e, upd_req} !== {x, m_pending}) begin
            errors++; $display("[TB] FAIL rstreq_enter: got %b expected %b", {e, upd_req}, {x, m_pending}); end
        tick(2);
        rst = 1'b1; tick(1); rst = 1'b0;
        m_reset();
        checks++; if ({upd_req, active_set, dut_outs} !== {1'b0, SEL_W'(0), def_timing()}) begin
            errors++; $display("[TB] FAIL rstreq_outs: got %h expected %h", {upd_req, active_set, dut_outs}, {1'b0, SEL_W'(0), def_timing()}); end
        for (int r = 0; r < 4; r++) begin
            rexp = m_read(12'h110 + 12'(4 * r));
            apb_read(12'h110 + 12'(4 * r), d, e);
            checks++; if ({e, d} !== rexp) begin errors++; $display("[TB] FAIL rstreq_set1_reg%0d: got %h expected %h", r, {e, d}, rexp); end
        end
    endtask

    task automatic test_live_update();
        logic        e;
        bit          x;
        logic [31:0] d, rd;
        logic [32:0] rexp;
        d = $urandom;
        x = m_write(12'h100 + 12'(16 * m_active), d);
        apb_write(12'h100 + 12'(16 * m_active), d, e);
        checks++; if ({e, upd_req} !== {x, m_pending}) begin
            errors++; $display("[TB] FAIL live_write: got %b expected %b", {e, upd_req}, {x, m_pending}); end
        rexp = m_read(12'h100 + 12'(16 * m_active));
        apb_read(12'h100 + 12'(16 * m_active), rd, e);
        checks++; if ({e, rd} !== rexp) begin errors++; $display("[TB] FAIL live_readback: got %h expected %h", {e, rd}, rexp); end
        upd_ack = 1'b1; tick(1); upd_ack = 1'b0; tick(1);
        if (m_pending) m_apply();
        checks++; if ({upd_req, dut_outs} !== {1'b0, m_out}) begin
            errors++; $display("[TB] FAIL live_outs: got %h expected %h", {upd_req, dut_outs}, {1'b0, m_out}); end
    endtask

    task automatic test_random();
        logic [11:0] a;
        logic [31:0] d, rd;
        logic [32:0] rexp;
        logic        e;
        bit          x;
        int          op, k;
        for (int i = 0; i < 300; i++) begin
            k = $urandom_range(0, 9);
            case (k)
                0: a = 12'h000;
                1: a = 12'h004;
                2: a = 12'($urandom_range(12'h200, 12'hFFF));
                3: a = 12'($urandom_range(12'h008, 12'h0FF));
                default: a = 12'h100 + 12'(16 * $urandom_range(0, NUM_SETS)) + 12'(4 * $urandom_range(0, 3));
            endcase
            a[1:0] = 2'($urandom_range(0, 3));
            d = (a[11:2] == 10'd0) ? 32'($urandom_range(0, NUM_SETS)) : $urandom;
            op = $urandom_range(0, 9);
            if (op < 4) begin
                x = m_write(a, d);
                apb_write(a, d, e);
                checks++; if (e !== x) begin errors++; $display("[TB] FAIL rnd%0d_wr a=%h: got %b expected %b", i, a, e, x); end
            end else if (op < 7) begin
                rexp = m_read(a);
                apb_read(a, rd, e);
                checks++; if (e !== rexp[32] || (!rexp[32] && rd !== rexp[31:0])) begin
                    errors++; $display("[TB] FAIL rnd%0d_rd a=%h: got %h expected %h", i, a, {e, rd}, rexp); end
            end else if (op < 9) begin
                upd_ack = 1'b1; tick(1); upd_ack = 1'b0; tick(1);
                if (m_pending) m_apply();
            end else begin
                tick(1);
            end
            checks++; if ({upd_req, active_set, dut_outs} !== {m_pending, SEL_W'(m_active), m_out}) begin
                errors++; $display("[TB] FAIL rnd%0d_state: got %h expected %h", i, {upd_req, active_set, dut_outs}, {m_pending, SEL_W'(m_active), m_out}); end
        end
    endtask

    initial begin
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; upd_ack = 1'b0;
        m_reset();
        test_reset();
        test_switch();
        test_errors();
        test_back_to_back();
        test_reset_in_req();
        test_live_update();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
